// File: rtl/huffman_dec.sv
// Serial six-symbol Huffman decoder, one bit per cycle.
// The code table is latched on tbl_load; symbols leave through a one-entry buffer.
module huffman_dec #(
  parameter int CODE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_load,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              sym_valid,
  output logic [2:0]        sym,
  input  logic              sym_ready,
  output logic              err,
  output logic              tbl_ok,
  output logic [CNT_W-1:0]  dec_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int LW = $clog2(CODE_W + 1);

  logic [CODE_W-1:0] hc_in [6];
  logic [CODE_W-1:0] m_in  [6];

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  logic [CODE_W-1:0] hc_q [6];
  logic [LW-1:0]     ln_q [6];
  logic [5:0]        en_q;
  logic [LW-1:0]     max_len;
  logic [CODE_W-2:0] acc;
  logic [LW-1:0]     len;

  function automatic logic [LW-1:0] popcnt(
    input logic [CODE_W-1:0] v
  );
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < CODE_W; i++)
      c = c + LW'(v[i]);
    return c;
  endfunction

  logic [LW-1:0] ln_d [6];
  logic [5:0]    en_d;
  logic [LW-1:0] max_d;

  // An entry counts only if its mask is a nonzero run of ones from bit 0.
  always_comb begin
    en_d  = '0;
    max_d = '0;
    for (int i = 0; i < 6; i++) begin
      ln_d[i] = popcnt(m_in[i]);
      en_d[i] = (m_in[i] != '0) &&
                (((m_in[i] + CODE_W'(1)) & m_in[i]) == '0);
      if (en_d[i] && ln_d[i] > max_d)
        max_d = ln_d[i];
    end
  end

  logic [CODE_W-1:0] nacc;
  logic [LW-1:0]     nlen;
  logic              hit;
  logic [2:0]        sel;
  logic              accept;

  assign bit_ready = tbl_ok & ~sym_valid;
  assign accept    = bit_valid & bit_ready & ~tbl_load;
  assign nacc      = {acc, bit_in};
  assign nlen      = len + LW'(1);

  // Scan downward so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 5; i >= 0; i--) begin
      if (en_q[i] && ln_q[i] == nlen && hc_q[i] == nacc) begin
        hit = 1'b1;
        sel = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        hc_q[i] <= '0;
        ln_q[i] <= '0;
      end
      en_q      <= '0;
      max_len   <= '0;
      acc       <= '0;
      len       <= '0;
      sym_valid <= 1'b0;
      sym       <= '0;
      err       <= 1'b0;
      tbl_ok    <= 1'b0;
      dec_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      if (sym_valid && sym_ready)
        sym_valid <= 1'b0;
      if (tbl_load) begin
        for (int i = 0; i < 6; i++) begin
          hc_q[i] <= hc_in[i] & m_in[i];
          ln_q[i] <= ln_d[i];
        end
        en_q    <= en_d;
        max_len <= max_d;
        tbl_ok  <= |en_d;
        acc     <= '0;
        len     <= '0;
        dec_cnt <= '0;
        err_cnt <= '0;
      end else if (accept) begin
        if (hit) begin
          sym       <= sel;
          sym_valid <= 1'b1;
          if (dec_cnt != '1)
            dec_cnt <= dec_cnt + CNT_W'(1);
          acc <= '0;
          len <= '0;
        end else if (nlen == max_len) begin
          err <= 1'b1;
          if (err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);
          acc <= '0;
          len <= '0;
        end else begin
          acc <= nacc[CODE_W-2:0];
          len <= nlen;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_dec.sv
// Bench for huffman_dec: directed table, corner sequences, random run.
// Counters are narrowed so saturation is reachable in a short run.
module tb_huffman_dec;

  localparam int CW = 8;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  logic clk = 1'b0;
  logic reset, tbl_load, bit_valid, bit_in, sym_ready;
  logic [CW-1:0] hc [6];
  logic [CW-1:0] mk [6];
  logic bit_ready, sym_valid, err, tbl_ok;
  logic [2:0] sym;
  logic [NW-1:0] dec_cnt, err_cnt;

  always #5 clk = ~clk;

  huffman_dec #(.CODE_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .tbl_load(tbl_load),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]),
    .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(mk[0]), .M2(mk[1]), .M3(mk[2]),
    .M4(mk[3]), .M5(mk[4]), .M6(mk[5]),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .sym_valid(sym_valid),
    .sym(sym), .sym_ready(sym_ready), .err(err),
    .tbl_ok(tbl_ok), .dec_cnt(dec_cnt),
    .err_cnt(err_cnt)
  );

  int vecs = 0;
  int bad = 0;

  // reference state: code table as (enable, length, value); bits seen so far
  int m_ok, m_symv, m_sym, m_err, m_dec, m_errc;
  int t_en [6];
  int t_len [6];
  int t_code [6];
  int t_max, a_val, a_len;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input int exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ok = 0; m_symv = 0; m_sym = 0; m_err = 0;
    m_dec = 0; m_errc = 0; t_max = 0;
    a_val = 0; a_len = 0;
    for (int i = 0; i < 6; i++) begin
      t_en[i] = 0; t_len[i] = 0; t_code[i] = 0;
    end
  endtask

  task automatic model_step(input int ld, input int bv,
                            input int b, input int sr);
    int rdy, found;
    rdy = m_ok && !m_symv;
    m_err = 0;
    if (m_symv && sr) m_symv = 0;
    if (ld) begin
      t_max = 0; m_ok = 0;
      for (int i = 0; i < 6; i++) begin
        int mm;
        mm = int'(mk[i]);
        t_en[i] = (mm != 0) && (((mm + 1) & mm) == 0);
        t_len[i] = $countones(mm);
        t_code[i] = int'(hc[i]) & mm;
        if (t_en[i]) begin
          m_ok = 1;
          if (t_len[i] > t_max) t_max = t_len[i];
        end
      end
      a_val = 0; a_len = 0; m_dec = 0; m_errc = 0;
    end else if (bv && rdy) begin
      a_val = a_val * 2 + b;
      a_len++;
      found = 0;
      for (int i = 0; i < 6; i++)
        if (!found && t_en[i] && t_len[i] == a_len
            && t_code[i] == a_val)
          found = i + 1;
      if (found != 0) begin
        m_symv = 1; m_sym = found;
        if (m_dec < SAT) m_dec++;
        a_val = 0; a_len = 0;
      end else if (a_len == t_max) begin
        m_err = 1;
        if (m_errc < SAT) m_errc++;
        a_val = 0; a_len = 0;
      end
    end
  endtask

  task automatic cycle(input int rs, input int ld, input int bv,
                       input int b, input int sr);
    reset = 1'(rs); tbl_load = 1'(ld);
    bit_valid = 1'(bv); bit_in = 1'(b); sym_ready = 1'(sr);
    if (rs) model_reset();
    else model_step(ld, bv, b, sr);
    @(posedge clk); #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bit_ready"}, 32'(bit_ready), m_ok && !m_symv);
    chk({tag, ".sym_valid"}, 32'(sym_valid), m_symv);
    chk({tag, ".sym"}, 32'(sym), m_sym);
    chk({tag, ".err"}, 32'(err), m_err);
    chk({tag, ".tbl_ok"}, 32'(tbl_ok), m_ok);
    chk({tag, ".dec_cnt"}, 32'(dec_cnt), m_dec);
    chk({tag, ".err_cnt"}, 32'(err_cnt), m_errc);
  endtask

  task automatic set_tbl1();
    for (int i = 0; i < 6; i++) begin
      hc[i] = (i == 5) ? 8'h00 : 8'h01;
      mk[i] = 8'((1 << (i < 5 ? i + 1 : 5)) - 1);
    end
  endtask

  typedef struct {
    int bv; int b;
    int symv; int sy; int rdy; int dec;
  } vec_t;

  vec_t tv [11];
  int errs_seen;

  initial begin
    set_tbl1();
    cycle(1, 0, 0, 0, 1);
    chk("rst.bit_ready", 32'(bit_ready), 0);
    chk("rst.sym_valid", 32'(sym_valid), 0);
    chk("rst.sym", 32'(sym), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.tbl_ok", 32'(tbl_ok), 0);
    chk("rst.dec_cnt", 32'(dec_cnt), 0);
    chk("rst.err_cnt", 32'(err_cnt), 0);

    // 1: stream 1 | 01 | 00000, stray bits during stalls ignored
    tv[0]  = '{1, 1, 1, 1, 0, 1};
    tv[1]  = '{1, 1, 0, 1, 1, 1};
    tv[2]  = '{1, 0, 0, 1, 1, 1};
    tv[3]  = '{1, 1, 1, 2, 0, 2};
    tv[4]  = '{1, 1, 0, 2, 1, 2};
    tv[5]  = '{1, 0, 0, 2, 1, 2};
    tv[6]  = '{1, 0, 0, 2, 1, 2};
    tv[7]  = '{1, 0, 0, 2, 1, 2};
    tv[8]  = '{1, 0, 0, 2, 1, 2};
    tv[9]  = '{1, 0, 1, 6, 0, 3};
    tv[10] = '{0, 0, 0, 6, 1, 3};
    cycle(0, 1, 0, 0, 1);
    chk("t1.tbl_ok", 32'(tbl_ok), 1);
    for (int i = 0; i < 11; i++) begin
      cycle(0, 0, tv[i].bv, tv[i].b, 1);
      chk($sformatf("t1[%0d].sym_valid", i), 32'(sym_valid), tv[i].symv);
      chk($sformatf("t1[%0d].sym", i), 32'(sym), tv[i].sy);
      chk($sformatf("t1[%0d].bit_ready", i), 32'(bit_ready), tv[i].rdy);
      chk($sformatf("t1[%0d].dec_cnt", i), 32'(dec_cnt), tv[i].dec);
      chk($sformatf("t1[%0d].err", i), 32'(err), 0);
    end

    // 2: back-pressure holds the symbol and blocks bits
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0);
      chk("t2.hold.sym_valid", 32'(sym_valid), 1);
      chk("t2.hold.bit_ready", 32'(bit_ready), 0);
      chk("t2.hold.dec_cnt", 32'(dec_cnt), 1);
    end
    cycle(0, 0, 0, 0, 1);
    chk("t2.rel.sym_valid", 32'(sym_valid), 0);
    chk("t2.rel.bit_ready", 32'(bit_ready), 1);

    // 3: max_len 2, "01" is undecodable, then "1"
    for (int i = 0; i < 6; i++) begin
      hc[i] = 8'h00; mk[i] = 8'h00;
    end
    hc[0] = 8'h01; mk[0] = 8'h01; mk[1] = 8'h03;
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    chk("t3.no_err_1st", 32'(err), 0);
    cycle(0, 0, 1, 1, 1);
    chk("t3.err", 32'(err), 1);
    chk("t3.err_cnt", 32'(err_cnt), 1);
    chk("t3.sym_valid", 32'(sym_valid), 0);
    cycle(0, 0, 1, 1, 1);
    chk("t3.err_pulse_end", 32'(err), 0);
    chk("t3.sym", 32'(sym), 1);
    chk("t3.sym_valid2", 32'(sym_valid), 1);
    cycle(0, 0, 0, 0, 1);

    // 4: empty table
    for (int i = 0; i < 6; i++) mk[i] = 8'h00;
    cycle(0, 1, 0, 0, 1);
    chk("t4.tbl_ok", 32'(tbl_ok), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, i % 2, 1);
      chk("t4.bit_ready", 32'(bit_ready), 0);
      chk("t4.sym_valid", 32'(sym_valid), 0);
      chk("t4.err", 32'(err), 0);
    end

    // 5: reload mid-code with a bit offered
    set_tbl1();
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 1, 1, 0, 1);
    chk("t5.dec_cnt", 32'(dec_cnt), 0);
    chk("t5.err_cnt", 32'(err_cnt), 0);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 1, 1);
    chk("t5.sym_valid", 32'(sym_valid), 1);
    chk("t5.sym", 32'(sym), 2);

    // 6: reset with symbol pending
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t6.pending", 32'(sym_valid), 1);
    cycle(1, 0, 1, 0, 0);
    check_all("t6");
    chk("t6.tbl_ok", 32'(tbl_ok), 0);

    // random: tables, loads, resets, back-pressure
    errs_seen = 0;
    for (int n = 0; n < 4000; n++) begin
      int ld, rs;
      rs = ($urandom_range(0, 999) < 4);
      ld = !rs && ($urandom_range(0, 99) < 2 || !m_ok);
      if (ld) begin
        if ($urandom_range(0, 2) == 0) set_tbl1();
        else
          for (int i = 0; i < 6; i++) begin
            hc[i] = 8'($urandom);
            case ($urandom_range(0, 9))
              0: mk[i] = 8'($urandom);
              1: mk[i] = 8'h00;
              default: mk[i] = 8'((1 << $urandom_range(1, 8)) - 1);
            endcase
          end
      end
      cycle(rs, ld, $urandom_range(0, 99) < 75,
            $urandom_range(0, 1), $urandom_range(0, 99) < 70);
      if (m_err) errs_seen++;
      check_all("rnd");
    end
    chk("rnd.saw_errors", 32'(errs_seen > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
